// File: rtl/prog_loader_if.sv
// Stream input and IMEM/DMEM write bus of the program loader.
// slave = loader side, master = host/pipeline side.
interface prog_loader_if #(
   parameter int IMEM_AW = 9,
   parameter int DMEM_AW = 8
) ();
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_data;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [63:0]        dmem_data;

   modport slave (
      input  in_valid, in_data,
      output in_ready,
      output imem_we, imem_addr, imem_data,
      output dmem_we, dmem_addr, dmem_data
   );

   modport master (
      output in_valid, in_data,
      input  in_ready,
      input  imem_we, imem_addr, imem_data,
      input  dmem_we, dmem_addr, dmem_data
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams IMEM then DMEM images in, then runs the pipe.
// Define LOADER_CHECKSUM_EN to add an XOR checksum word per segment.
module prog_loader #(
   parameter int IMEM_AW     = 9,
   parameter int DMEM_AW     = 8,
   parameter int HALT_PC     = 47,
   parameter int RUN_TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   prog_loader_if.slave       bus,
   input  logic [IMEM_AW-1:0] pc,
   output logic               pipe_en,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [2:0]         err_code
);

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_IHDR  = 4'd1;
   localparam logic [3:0] ST_ILOAD = 4'd2;
   localparam logic [3:0] ST_DHDR  = 4'd4;
   localparam logic [3:0] ST_DLO   = 4'd5;
   localparam logic [3:0] ST_DHI   = 4'd6;
   localparam logic [3:0] ST_RUN   = 4'd8;
   localparam logic [3:0] ST_DONE  = 4'd9;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [3:0] ST_ICSUM = 4'd3;
   localparam logic [3:0] ST_DCSUM = 4'd7;
   localparam logic [3:0] I_NEXT   = ST_ICSUM;
   localparam logic [3:0] D_NEXT   = ST_DCSUM;
`else
   localparam logic [3:0] I_NEXT   = ST_DHDR;
   localparam logic [3:0] D_NEXT   = ST_RUN;
`endif

   localparam logic [16:0] IMAX   = 17'(2**IMEM_AW);
   localparam logic [16:0] DMAX   = 17'(2**DMEM_AW);
   localparam logic [31:0] HALT_W = 32'(HALT_PC);
   localparam logic [31:0] RUN_W  = 32'(RUN_TIMEOUT);

   logic [3:0]         state_q, state_d;
   logic [16:0]        cnt_q, cnt_d;
   logic [16:0]        n_q, n_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        run_cnt_q, run_cnt_d;
   logic               pipe_en_q, pipe_en_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [2:0]         err_code_q, err_code_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]        imem_data_q, imem_data_d;
   logic               dmem_we_q, dmem_we_d;
   logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
   logic [63:0]        dmem_data_q, dmem_data_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]        csum_q, csum_d;
`endif

   logic        in_ready;
   logic        accept;
   logic [16:0] hdr;
   logic [16:0] cnt_inc;
   logic        last;
   logic        halt_hit;

   // Stream is accepted only in header, load and checksum states.
   always_comb begin
      in_ready = (state_q == ST_IHDR) || (state_q == ST_ILOAD) ||
                 (state_q == ST_DHDR) || (state_q == ST_DLO) ||
`ifdef LOADER_CHECKSUM_EN
                 (state_q == ST_ICSUM) || (state_q == ST_DCSUM) ||
`endif
                 (state_q == ST_DHI);
   end

   assign accept   = bus.in_valid && in_ready;
   assign hdr      = {1'b0, bus.in_data[15:0]};
   assign cnt_inc  = cnt_q + 17'd1;
   assign last     = (cnt_inc == n_q);
   assign halt_hit = ({{(32-IMEM_AW){1'b0}}, pc} >= HALT_W);

   // Next-state, write strobes, run control and sticky status.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      lo_d        = lo_q;
      run_cnt_d   = run_cnt_q;
      pipe_en_d   = pipe_en_q;
      done_d      = done_q;
      err_d       = err_q;
      err_code_d  = err_code_q;
      imem_we_d   = 1'b0;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;
      dmem_we_d   = 1'b0;
      dmem_addr_d = dmem_addr_q;
      dmem_data_d = dmem_data_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_IHDR;
               run_cnt_d = '0;
            end
         end
         ST_IHDR: begin
            if (accept) begin
               n_d   = hdr;
               cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d = '0;
`endif
               if (hdr > IMAX) begin
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  err_code_d = 3'd1;
                  state_d    = ST_DONE;
               end else if (hdr == 17'd0) begin
                  state_d = I_NEXT;
               end else begin
                  state_d = ST_ILOAD;
               end
            end
         end
         ST_ILOAD: begin
            if (accept) begin
               imem_we_d   = 1'b1;
               imem_addr_d = cnt_q[IMEM_AW-1:0];
               imem_data_d = bus.in_data;
               cnt_d       = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               if (last) state_d = I_NEXT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_ICSUM: begin
            if (accept) begin
               if (bus.in_data != csum_q) begin
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  err_code_d = 3'd4;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_DHDR;
               end
            end
         end
`endif
         ST_DHDR: begin
            if (accept) begin
               n_d   = hdr;
               cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d = '0;
`endif
               if (hdr > DMAX) begin
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  err_code_d = 3'd2;
                  state_d    = ST_DONE;
               end else if (hdr == 17'd0) begin
                  state_d = D_NEXT;
               end else begin
                  state_d = ST_DLO;
               end
            end
         end
         ST_DLO: begin
            if (accept) begin
               lo_d    = bus.in_data;
               state_d = ST_DHI;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
            end
         end
         ST_DHI: begin
            if (accept) begin
               dmem_we_d   = 1'b1;
               dmem_addr_d = cnt_q[DMEM_AW-1:0];
               dmem_data_d = {bus.in_data, lo_q};
               cnt_d       = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               state_d = last ? D_NEXT : ST_DLO;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_DCSUM: begin
            if (accept) begin
               if (bus.in_data != csum_q) begin
                  err_d      = 1'b1;
                  done_d     = 1'b1;
                  err_code_d = 3'd4;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
`endif
         ST_RUN: begin
            // Halt is checked first so it wins over a same-cycle timeout.
            if (halt_hit) begin
               pipe_en_d = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else if (pipe_en_q && (run_cnt_q + 32'd1 == RUN_W)) begin
               pipe_en_d  = 1'b0;
               done_d     = 1'b1;
               err_d      = 1'b1;
               err_code_d = 3'd3;
               state_d    = ST_DONE;
            end else begin
               pipe_en_d = 1'b1;
               if (pipe_en_q) run_cnt_d = run_cnt_q + 32'd1;
            end
         end
         ST_DONE: begin
            if (start) begin
               done_d     = 1'b0;
               err_d      = 1'b0;
               err_code_d = 3'd0;
               run_cnt_d  = '0;
               state_d    = ST_IHDR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         lo_q        <= '0;
         run_cnt_q   <= '0;
         pipe_en_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         dmem_we_q   <= 1'b0;
         dmem_addr_q <= '0;
         dmem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         lo_q        <= lo_d;
         run_cnt_q   <= run_cnt_d;
         pipe_en_q   <= pipe_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         imem_we_q   <= imem_we_d;
         imem_addr_q <= imem_addr_d;
         imem_data_q <= imem_data_d;
         dmem_we_q   <= dmem_we_d;
         dmem_addr_q <= dmem_addr_d;
         dmem_data_q <= dmem_data_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.imem_we   = imem_we_q;
   assign bus.imem_addr = imem_addr_q;
   assign bus.imem_data = imem_data_q;
   assign bus.dmem_we   = dmem_we_q;
   assign bus.dmem_addr = dmem_addr_q;
   assign bus.dmem_data = dmem_data_q;
   assign pipe_en       = pipe_en_q;
   assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;

endmodule
